// File: rtl/throttle_controller.sv
// Throttle controller: turns decoded signed power samples into a rate-limited
// motor duty and direction, with a forward/brake/neutral/reverse interlock and loss-of-signal failsafe.
module throttle_controller #(
  parameter int K_RES   = 10,
  parameter int K_CNT_W = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic signed [K_RES-1:0]   i_power,
  input  logic                      i_power_done,
  input  logic                      i_brake,
  input  logic                      i_timebase,
  input  logic                      i_enable,
  input  logic        [K_RES-2:0]   i_neutral_band,
  input  logic        [K_RES-2:0]   i_ramp_step,
  input  logic        [K_CNT_W-1:0] i_timeout,
  input  logic        [K_CNT_W-1:0] i_rev_dwell,
  output logic        [K_RES-2:0]   o_duty,
  output logic                      o_dir,
  output logic                      o_brake_active,
  output logic                      o_failsafe,
  output logic        [2:0]         o_state,
  output logic                      o_duty_valid
);

  localparam int MW = K_RES - 1;
  localparam logic [K_CNT_W-1:0] CNT_ONE = K_CNT_W'(1);
  localparam logic [K_RES-1:0]   PWR_ONE = K_RES'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NEUTRAL = 3'd1,
    ST_FWD     = 3'd2,
    ST_BRAKE   = 3'd3,
    ST_REV     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [MW-1:0]      duty_q, duty_d;
  logic               dir_q, dir_d;
  logic               brake_q, brake_d;
  logic               failsafe_q, failsafe_d;
  logic               valid_q, valid_d;
  logic [K_CNT_W-1:0] dwell_q, dwell_d;
  logic [K_CNT_W-1:0] timeout_q, timeout_d;

  logic [K_RES-1:0]   pwr_u;
  logic [K_RES-1:0]   abs_full;
  logic [MW-1:0]      mag;
  logic [MW-1:0]      ramp_duty;
  logic               pwr_neg, is_neutral, is_pos, is_neg;
  logic               timeout_fire, sample_taken;

  // Magnitude saturates so the most negative code maps to full scale.
  always_comb begin
    pwr_u      = i_power;
    pwr_neg    = pwr_u[K_RES-1];
    abs_full   = pwr_neg ? (~pwr_u + PWR_ONE) : pwr_u;
    mag        = abs_full[K_RES-1] ? {MW{1'b1}} : abs_full[MW-1:0];
    is_neutral = (mag <= i_neutral_band);
    is_pos     = !pwr_neg && !is_neutral;
    is_neg     = pwr_neg && !is_neutral;
    // Increases are limited to one step per sample; decreases are immediate.
    if (mag > duty_q && i_ramp_step != '0 && (mag - duty_q) > i_ramp_step) begin
      ramp_duty = duty_q + i_ramp_step;
    end else begin
      ramp_duty = mag;
    end
  end

  // Fires only on the tick that makes the counter reach the limit; a sample in
  // the same cycle wins.
  assign timeout_fire = (i_timeout != '0) && i_timebase && !i_power_done &&
                        !(&timeout_q) && ((timeout_q + CNT_ONE) == i_timeout);
  assign sample_taken = i_enable && i_power_done;

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    failsafe_d = failsafe_q;
    valid_d    = 1'b0;

    if (!i_enable) begin
      state_d = ST_IDLE;
      valid_d = i_power_done;
    end else if (i_power_done) begin
      valid_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (is_neutral) begin
            state_d    = ST_NEUTRAL;
            failsafe_d = 1'b0;
          end
        end
        ST_NEUTRAL: begin
          if (is_pos) begin
            state_d = ST_FWD;
          end else if (is_neg && dwell_q >= i_rev_dwell) begin
            state_d = ST_REV;
          end
        end
        ST_FWD: begin
          if (is_neg || i_brake) state_d = ST_BRAKE;
          else if (is_neutral)   state_d = ST_NEUTRAL;
        end
        ST_REV: begin
          if (is_pos || i_brake) state_d = ST_BRAKE;
          else if (is_neutral)   state_d = ST_NEUTRAL;
        end
        ST_BRAKE: begin
          if (is_neutral) state_d = ST_NEUTRAL;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_fire) begin
      state_d    = ST_IDLE;
      failsafe_d = 1'b1;
      valid_d    = 1'b1;
    end

    if (state_d != ST_FWD && state_d != ST_REV) begin
      duty_d = '0;
    end else if (sample_taken) begin
      duty_d = ramp_duty;
    end
    dir_d   = (state_d == ST_REV);
    brake_d = (state_d == ST_BRAKE);

    timeout_d = timeout_q;
    if (i_power_done) begin
      timeout_d = '0;
    end else if (i_timebase && !(&timeout_q)) begin
      timeout_d = timeout_q + CNT_ONE;
    end

    dwell_d = dwell_q;
    if (state_d == ST_NEUTRAL && state_q != ST_NEUTRAL) begin
      dwell_d = '0;
    end else if (state_q == ST_NEUTRAL && i_timebase && !(&dwell_q)) begin
      dwell_d = dwell_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      brake_q    <= 1'b0;
      failsafe_q <= 1'b1;
      valid_q    <= 1'b0;
      dwell_q    <= '0;
      timeout_q  <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      brake_q    <= brake_d;
      failsafe_q <= failsafe_d;
      valid_q    <= valid_d;
      dwell_q    <= dwell_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_duty         = duty_q;
  assign o_dir          = dir_q;
  assign o_brake_active = brake_q;
  assign o_failsafe     = failsafe_q;
  assign o_state        = state_q;
  assign o_duty_valid   = valid_q;

endmodule

// File: tb/tb_throttle_controller.sv
// Self-checking bench for throttle_controller: per-feature test tasks plus a
// scoreboard of expected {state, duty, dir, brake, failsafe} popped on each o_duty_valid.
module tb_throttle_controller;

  localparam int K_RES   = 10;
  localparam int K_CNT_W = 16;

  logic                      clk;
  logic                      i_rst;
  logic signed [K_RES-1:0]   i_power;
  logic                      i_power_done;
  logic                      i_brake;
  logic                      i_timebase;
  logic                      i_enable;
  logic        [K_RES-2:0]   i_neutral_band;
  logic        [K_RES-2:0]   i_ramp_step;
  logic        [K_CNT_W-1:0] i_timeout;
  logic        [K_CNT_W-1:0] i_rev_dwell;
  logic        [K_RES-2:0]   o_duty;
  logic                      o_dir;
  logic                      o_brake_active;
  logic                      o_failsafe;
  logic        [2:0]         o_state;
  logic                      o_duty_valid;

  throttle_controller #(.K_RES(K_RES), .K_CNT_W(K_CNT_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_power(i_power), .i_power_done(i_power_done),
    .i_brake(i_brake), .i_timebase(i_timebase), .i_enable(i_enable),
    .i_neutral_band(i_neutral_band), .i_ramp_step(i_ramp_step),
    .i_timeout(i_timeout), .i_rev_dwell(i_rev_dwell), .o_duty(o_duty),
    .o_dir(o_dir), .o_brake_active(o_brake_active), .o_failsafe(o_failsafe),
    .o_state(o_state), .o_duty_valid(o_duty_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [14:0] exp_q[$];
  logic [14:0] obs;
  assign obs = {o_state, o_duty, o_dir, o_brake_active, o_failsafe};

  function automatic logic [14:0] pk(input int s, input int d, input int dr, input int br, input int fs);
    return {3'(s), 9'(d), 1'(dr), 1'(br), 1'(fs)};
  endfunction

  // Scoreboard
  always @(negedge clk) begin
    if (o_duty_valid) begin
      logic [14:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_valid: got state=%0d duty=%0d dir=%0d brake=%0d fs=%0d, required no strobe",
                 o_state, o_duty, o_dir, o_brake_active, o_failsafe);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          $display("FAIL sb_sample: got state=%0d duty=%0d dir=%0d brake=%0d fs=%0d, required state=%0d duty=%0d dir=%0d brake=%0d fs=%0d",
                   o_state, o_duty, o_dir, o_brake_active, o_failsafe,
                   e[14:12], e[11:3], e[2], e[1], e[0]);
        end else begin
          passes++;
        end
      end
    end
  end

  // Drivers
  task automatic sample(input int p, input logic b, input logic tick, input logic [14:0] e);
    @(negedge clk);
    i_power      = K_RES'(p);
    i_brake      = b;
    i_timebase   = tick;
    i_power_done = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    i_power_done = 1'b0;
    i_timebase   = 1'b0;
    i_brake      = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_timebase = 1'b1;
      @(negedge clk);
      i_timebase = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 0, 1) || o_duty_valid !== 1'b0) begin
      $display("FAIL reset_values: got state=%0d duty=%0d dir=%0d brake=%0d fs=%0d valid=%0d, required 0 0 0 0 1 0",
               o_state, o_duty, o_dir, o_brake_active, o_failsafe, o_duty_valid);
    end else passes++;
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_acquire();
    sample(0, 0, 0, pk(1, 0, 0, 0, 0));
    checks++;
    if (o_duty_valid !== 1'b0 || o_state !== 3'd1) begin
      $display("FAIL acquire_single_pulse: got valid=%0d state=%0d, required valid=0 state=1",
               o_duty_valid, o_state);
    end else passes++;
  endtask

  task automatic test_ramp();
    i_ramp_step = 9'd100;
    sample(300, 0, 0, pk(2, 100, 0, 0, 0));
    sample(300, 0, 0, pk(2, 200, 0, 0, 0));
    sample(300, 0, 0, pk(2, 300, 0, 0, 0));
    sample(300, 0, 0, pk(2, 300, 0, 0, 0));
    sample(50, 0, 0, pk(2, 50, 0, 0, 0));
    sample(9, 0, 0, pk(2, 9, 0, 0, 0));
    sample(8, 0, 0, pk(1, 0, 0, 0, 0));
    sample(300, 0, 0, pk(2, 100, 0, 0, 0));
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL ramp_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end else passes++;
  endtask

  task automatic test_reverse();
    i_rev_dwell = 16'd4;
    sample(-200, 0, 0, pk(3, 0, 0, 1, 0));
    checks++;
    if (o_brake_active !== 1'b1) begin
      $display("FAIL rev_brake_flag: got %0d, required 1", o_brake_active);
    end else passes++;
    sample(0, 0, 0, pk(1, 0, 0, 0, 0));
    ticks(2);
    sample(-200, 0, 0, pk(1, 0, 0, 0, 0));
    ticks(2);
    sample(-200, 0, 0, pk(4, 100, 1, 0, 0));
    sample(-200, 0, 0, pk(4, 200, 1, 0, 0));
    sample(50, 0, 0, pk(3, 0, 0, 1, 0));
    sample(-8, 0, 0, pk(1, 0, 0, 0, 0));
    sample(-200, 0, 0, pk(1, 0, 0, 0, 0));
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL reverse_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end else passes++;
  endtask

  task automatic test_timeout();
    sample(300, 0, 0, pk(2, 100, 0, 0, 0));
    sample(300, 0, 0, pk(2, 200, 0, 0, 0));
    sample(300, 0, 0, pk(2, 300, 0, 0, 0));
    i_timeout = 16'd3;
    ticks(2);
    checks++;
    if (o_failsafe !== 1'b0 || o_state !== 3'd2) begin
      $display("FAIL timeout_early: got fs=%0d state=%0d, required fs=0 state=2", o_failsafe, o_state);
    end else passes++;
    exp_q.push_back(pk(0, 0, 0, 0, 1));
    ticks(1);
    @(negedge clk);
    checks++;
    if (o_failsafe !== 1'b1 || o_state !== 3'd0 || o_duty !== 9'd0) begin
      $display("FAIL timeout_fire: got fs=%0d state=%0d duty=%0d, required fs=1 state=0 duty=0",
               o_failsafe, o_state, o_duty);
    end else passes++;
    sample(300, 0, 0, pk(0, 0, 0, 0, 1));
    sample(0, 0, 0, pk(1, 0, 0, 0, 0));
    sample(300, 0, 0, pk(2, 100, 0, 0, 0));
    ticks(2);
    sample(300, 0, 1, pk(2, 200, 0, 0, 0));
    ticks(2);
    checks++;
    if (o_failsafe !== 1'b0 || o_state !== 3'd2 || exp_q.size() != 0) begin
      $display("FAIL timeout_coincident: got fs=%0d state=%0d pending=%0d, required fs=0 state=2 pending=0",
               o_failsafe, o_state, exp_q.size());
      exp_q.delete();
    end else passes++;
    i_timeout = 16'd0;
  endtask

  task automatic test_saturation();
    i_ramp_step = 9'd0;
    sample(0, 0, 0, pk(1, 0, 0, 0, 0));
    ticks(4);
    sample(-100, 0, 0, pk(4, 100, 1, 0, 0));
    sample(-512, 0, 0, pk(4, 511, 1, 0, 0));
    sample(-100, 1, 0, pk(3, 0, 0, 1, 0));
    sample(0, 0, 0, pk(1, 0, 0, 0, 0));
    sample(511, 0, 0, pk(2, 511, 0, 0, 0));
    sample(200, 1, 0, pk(3, 0, 0, 1, 0));
    sample(0, 0, 0, pk(1, 0, 0, 0, 0));
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL saturation_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end else passes++;
  endtask

  task automatic test_enable();
    sample(300, 0, 0, pk(2, 300, 0, 0, 0));
    @(negedge clk);
    i_enable = 1'b0;
    @(negedge clk);
    checks++;
    if (o_state !== 3'd0 || o_duty !== 9'd0 || o_failsafe !== 1'b0 || o_dir !== 1'b0) begin
      $display("FAIL enable_low: got state=%0d duty=%0d fs=%0d dir=%0d, required 0 0 0 0",
               o_state, o_duty, o_failsafe, o_dir);
    end else passes++;
    i_enable = 1'b1;
    sample(0, 0, 0, pk(1, 0, 0, 0, 0));
    @(negedge clk);
    i_enable     = 1'b0;
    i_power      = 10'sd300;
    i_power_done = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    @(negedge clk);
    i_power_done = 1'b0;
    @(negedge clk);
    checks++;
    if (o_state !== 3'd0 || exp_q.size() != 0) begin
      $display("FAIL enable_vs_sample: got state=%0d pending=%0d, required state=0 pending=0",
               o_state, exp_q.size());
      exp_q.delete();
    end else passes++;
    i_enable = 1'b1;
  endtask

  task automatic test_random_ramp();
    int duty;
    int mag;
    int step;
    duty = 0;
    sample(0, 0, 0, pk(1, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      mag  = $urandom_range(9, 511);
      step = $urandom_range(0, 150);
      i_ramp_step = 9'(step);
      if (mag > duty && step != 0 && (mag - duty) > step) duty = duty + step;
      else duty = mag;
      sample(mag, 0, 0, pk(2, duty, 0, 0, 0));
    end
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL random_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end else passes++;
  endtask

  task automatic test_reset_mid();
    i_ramp_step = 9'd100;
    sample(0, 0, 0, pk(1, 0, 0, 0, 0));
    sample(300, 0, 0, pk(2, 100, 0, 0, 0));
    sample(300, 0, 0, pk(2, 200, 0, 0, 0));
    @(negedge clk);
    i_rst        = 1'b1;
    i_power      = 10'sd300;
    i_power_done = 1'b1;
    i_timebase   = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== pk(0, 0, 0, 0, 1) || o_duty_valid !== 1'b0) begin
      $display("FAIL reset_mid: got state=%0d duty=%0d dir=%0d brake=%0d fs=%0d valid=%0d, required 0 0 0 0 1 0",
               o_state, o_duty, o_dir, o_brake_active, o_failsafe, o_duty_valid);
    end else passes++;
    i_rst        = 1'b0;
    i_power_done = 1'b0;
    i_timebase   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    i_rst          = 1'b1;
    i_power        = '0;
    i_power_done   = 1'b0;
    i_brake        = 1'b0;
    i_timebase     = 1'b0;
    i_enable       = 1'b1;
    i_neutral_band = 9'd8;
    i_ramp_step    = 9'd100;
    i_timeout      = 16'd0;
    i_rev_dwell    = 16'd4;
    test_reset();
    test_acquire();
    test_ramp();
    test_reverse();
    test_timeout();
    test_saturation();
    test_enable();
    test_random_ramp();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL final_drain: got %0d pending, required 0", exp_q.size());
    end else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/throttle_controller.md
# throttle_controller

Downstream consumer of the RC channel decoder's power outputs. It turns each decoded signed power sample into a rate-limited unsigned motor duty and a direction bit. It enforces an ESC-style forward/brake/neutral/reverse interlock and a loss-of-signal failsafe, and feeds the motor PWM generator.

## Interface
- K_RES, 10: width of the signed power sample; duty magnitude is K_RES-1 bits.
- K_CNT_W, 16: width of timeout and dwell counters.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; one clock, reset is synchronous and active-high.
- i_power  in  K_RES  signed two's-complement power sample; positive = forward.
- i_power_done  in  1  one-cycle strobe; i_power is valid this cycle.
- i_brake  in  1  decoder brake flag, sampled with i_power_done.
- i_timebase  in  1  one-cycle tick used by all counters.
- i_enable  in  1  level; low forces IDLE.
- i_neutral_band  in  K_RES-1  magnitudes <= band are treated as neutral.
- i_ramp_step  in  K_RES-1  maximum duty increase per sample; 0 disables the ramp.
- i_timeout  in  K_CNT_W  ticks without a sample before failsafe; 0 disables the timeout.
- i_rev_dwell  in  K_CNT_W  neutral ticks required before reverse is allowed.
- o_duty  out  K_RES-1  unsigned duty magnitude.
- o_dir  out  1  1 = reverse.
- o_brake_active  out  1  high in BRAKE.
- o_failsafe  out  1  signal lost or never acquired.
- o_state  out  3  IDLE=0, NEUTRAL=1, FWD=2, BRAKE=3, REV=4.
- o_duty_valid  out  1  one-cycle strobe when o_duty/o_dir were updated.

## Operation
- Magnitude: mag = |i_power|, computed on K_RES bits and saturated to 2^(K_RES-1)-1 (so -512 gives 511).
- Sample classes:
  - neutral: mag <= i_neutral_band.
  - pos: i_power >= 0 and not neutral.
  - neg: i_power < 0 and not neutral.
- State transitions are evaluated only on i_power_done, except the i_enable and timeout overrides below.
- IDLE: neutral sample with i_enable=1 -> NEUTRAL, o_failsafe cleared. Any other sample: stay in IDLE.
- NEUTRAL:
  - pos -> FWD.
  - neg with dwell count >= i_rev_dwell -> REV.
  - neg with dwell unmet -> stay, duty 0.
- FWD:
  - neg or i_brake -> BRAKE.
  - neutral -> NEUTRAL.
  - pos -> stay.
- REV:
  - pos or i_brake -> BRAKE.
  - neutral -> NEUTRAL.
  - neg -> stay.
- BRAKE: neutral -> NEUTRAL; otherwise stay.
- Duty:
  - FWD/REV: target = mag. If target > duty, duty += min(i_ramp_step, target-duty), or duty = target when step = 0. Otherwise duty = target immediately (decrease is never rate-limited).
  - All other states: duty = 0.
- o_dir = 1 only in REV; 0 elsewhere. o_brake_active = (state == BRAKE).
- Dwell counter:
  - Cleared on entry to NEUTRAL.
  - Increments on i_timebase while in NEUTRAL.
  - Saturates at all-ones.
- Timeout counter:
  - Cleared on i_power_done.
  - Increments on i_timebase; saturates.
  - When it equals i_timeout (i_timeout != 0): state -> IDLE, duty 0, o_dir 0, o_failsafe 1, o_duty_valid pulses.
- i_enable low: state -> IDLE and duty 0 on the next edge; o_failsafe is unchanged.

## Timing
- All outputs are registered.
- Reset values: o_duty 0, o_dir 0, o_brake_active 0, o_failsafe 1, o_state IDLE, o_duty_valid 0, both counters 0.
- Latency: i_power_done at edge N -> new state/o_duty/o_dir visible after edge N+1, with o_duty_valid high for exactly that one cycle.
- Only one ramp step is taken per sample, regardless of how many clocks separate samples.
- Simultaneous i_power_done and the timeout-reaching tick: the sample wins; the counter clears, no failsafe.
- Simultaneous i_enable low and a sample: IDLE wins.
- Failsafe timing: triggered in the cycle the counter reaches i_timeout, so outputs change one cycle after that tick.
- Reset asserted mid-operation: all outputs and counters return to reset values at the next edge, independent of other inputs.

## Test plan
- Acquire: after reset o_failsafe=1, o_state=0. Sample i_power=0 -> o_state=1, o_failsafe=0, o_duty=0, one o_duty_valid pulse.
- Ramp: i_ramp_step=100, NEUTRAL, four samples of +300 -> o_state=2, o_duty 100, 200, 300, 300. Then sample +50 -> o_duty=50 immediately.
- Reverse interlock with i_rev_dwell=4:
  - From FWD, sample -200 -> BRAKE, o_brake_active=1, o_duty=0.
  - Sample 0 -> NEUTRAL.
  - Sample -200 after 2 ticks -> stays NEUTRAL, o_duty 0.
  - Sample -200 after 4 ticks -> REV, o_dir=1, o_duty=100.
- Timeout: i_timeout=3, FWD with o_duty=300, three ticks with no sample -> o_failsafe=1, o_state=0, o_duty=0.
  - Next sample +300 -> stays IDLE.
  - Sample 0 -> NEUTRAL.
  - Repeat with i_power_done coinciding with the third tick -> no failsafe.
- Saturation/brake: i_ramp_step=0, REV, sample i_power=10'h200 -> o_duty=511. Then sample -100 with i_brake=1 -> BRAKE, o_duty=0.
- Enable/reset: in FWD deassert i_enable -> IDLE next edge with o_failsafe unchanged. Assert i_rst mid-ramp -> all outputs at reset values next edge.
